// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared state enum and default 10 MHz WS2812 timing constants
package ws2812_pkg;
  typedef enum logic {LATCH, SEND} state_e;
  localparam int DEF_T0H_CYC = 4;
  localparam int DEF_T1H_CYC = 8;
  localparam int DEF_BIT_CYC = 13;
  localparam int DEF_LATCH_CYC = 500;
  localparam int FRAME_BITS = 24;
endpackage

// File: rtl/ws2812_if.sv
// ws2812_if: level0/1/2 (R/G/B) + enable from host; led_dout, busy, frame_done back from driver
interface ws2812_if;
  logic [7:0] level0, level1, level2;
  logic enable, led_dout, busy, frame_done;
  modport master(output level0, level1, level2, enable, input led_dout, busy, frame_done);
  modport slave(input level0, level1, level2, enable, output led_dout, busy, frame_done);
endinterface

// File: rtl/ws2812_driver.sv
// ws2812_driver: GRB frame serializer; clk, reset (sync high), bus (ws2812_if.slave: levels/enable in, led_dout/busy/frame_done out)
module ws2812_driver
  import ws2812_pkg::*;
#(
  parameter int T0H_CYC = DEF_T0H_CYC,
  parameter int T1H_CYC = DEF_T1H_CYC,
  parameter int BIT_CYC = DEF_BIT_CYC,
  parameter int LATCH_CYC = DEF_LATCH_CYC
) (
  input logic clk,
  input logic reset,
  ws2812_if.slave bus
);
  localparam int CW = $clog2(((BIT_CYC > LATCH_CYC) ? BIT_CYC : LATCH_CYC) + 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYC - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] T0H = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H = CW'(T1H_CYC);
  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);
  if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC && LATCH_CYC >= 1)) begin : g_bad_params
    $error("ws2812_driver: illegal timing parameters");
  end
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [4:0] bit_q;
  logic [23:0] sr_q;
  logic led_q, done_q;
  logic latch_end, bit_end, frame_end;
  assign latch_end = state_q == LATCH && cnt_q == LATCH_LAST;
  assign bit_end = state_q == SEND && cnt_q == BIT_LAST;
  assign frame_end = bit_end && bit_q == LAST_BIT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LATCH;
      cnt_q <= '0;
      bit_q <= '0;
      sr_q <= '0;
      led_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      led_q <= state_q == SEND && cnt_q < (sr_q[23] ? T1H : T0H);
      done_q <= frame_end;
      if (state_q == LATCH) begin
        if (!latch_end) cnt_q <= cnt_q + 1'b1;
        else if (bus.enable) begin
          state_q <= SEND;
          cnt_q <= '0;
          bit_q <= '0;
          sr_q <= {bus.level1, bus.level0, bus.level2};
        end
      end else if (bit_end) begin
        cnt_q <= '0;
        sr_q <= sr_q << 1;
        bit_q <= frame_end ? '0 : bit_q + 1'b1;
        state_q <= frame_end ? LATCH : SEND;
      end else cnt_q <= cnt_q + 1'b1;
    end
  end
  assign bus.led_dout = led_q;
  assign bus.busy = state_q == SEND;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_ws2812_driver.sv
// tb_ws2812_driver: directed self-checking bench for ws2812_driver
module tb_ws2812_driver;
  logic clk = 1'b0;
  logic reset;
  int vectors = 0;
  int miscompares = 0;
  ws2812_if bus();
  ws2812_driver dut(.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_rise(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.led_dout && n < 5000);
  endtask
  task automatic run_frame(input string tag, input logic [23:0] bits, input int chg_bit);
    logic [12:0] shape;
    for (int b = 0; b < 24; b++) begin
      shape = '0;
      for (int c = 0; c < 13; c++) begin
        if (b != 0 || c != 0) step();
        if (b == chg_bit && c == 0) begin
          bus.level0 = 8'h00;
          bus.level1 = 8'h00;
          bus.level2 = 8'h00;
        end
        shape[12-c] = bus.led_dout;
        if (b == 23 && c == 11) begin
          check({tag, "_done_early"}, int'(bus.frame_done), 0);
          check({tag, "_busy_last"}, int'(bus.busy), 1);
        end
        if (b == 23 && c == 12) begin
          check({tag, "_done"}, int'(bus.frame_done), 1);
          check({tag, "_busy_off"}, int'(bus.busy), 0);
        end
      end
      check($sformatf("%s_bit%0d", tag, b), int'(shape), bits[23-b] ? 13'h1FE0 : 13'h1E00);
    end
    step();
    check({tag, "_done_1cyc"}, int'(bus.frame_done), 0);
  endtask
  initial begin
    int n, hi, bz;
    reset = 1'b1;
    bus.level0 = 8'hFF;
    bus.level1 = 8'hFF;
    bus.level2 = 8'hFF;
    bus.enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("rst_outs%0d", i), int'({bus.led_dout, bus.busy, bus.frame_done}), 0);
    end
    bus.level1 = 8'hFF;
    bus.level0 = 8'h00;
    bus.level2 = 8'hAA;
    reset = 1'b0;
    wait_rise(n);
    check("first_rise", n, 501);
    run_frame("f1", 24'hFF00AA, -1);
    wait_rise(n);
    check("f2_rise", n, 500);
    run_frame("f2", 24'hFF00AA, 5);
    wait_rise(n);
    check("f3_rise", n, 500);
    run_frame("f3", 24'h000000, -1);
    bus.enable = 1'b0;
    hi = 0;
    bz = 0;
    for (int i = 0; i < 700; i++) begin
      step();
      hi += int'(bus.led_dout);
      bz += int'(bus.busy);
    end
    check("hold_led", hi, 0);
    check("hold_busy", bz, 0);
    bus.level1 = 8'h12;
    bus.level0 = 8'h34;
    bus.level2 = 8'h56;
    bus.enable = 1'b1;
    wait_rise(n);
    check("enable_rise", n, 2);
    run_frame("f4", 24'h123456, -1);
    bus.level0 = 8'hFF;
    bus.level1 = 8'hFF;
    bus.level2 = 8'hFF;
    wait_rise(n);
    check("f5_rise", n, 500);
    for (int i = 0; i < 132; i++) step();
    check("bit10_high", int'(bus.led_dout), 1);
    reset = 1'b1;
    step();
    check("rst_led", int'(bus.led_dout), 0);
    check("rst_busy", int'(bus.busy), 0);
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    wait_rise(n);
    check("rerise", n, 501);
    n = 0;
    while (!bus.frame_done && n < 1000) begin
      step();
      n++;
    end
    check("run_done_seen", int'(bus.frame_done), 1);
    for (int f = 0; f < 3; f++) begin
      n = 0;
      bz = 0;
      do begin
        step();
        n++;
        bz += int'(bus.busy);
      end while (!bus.frame_done && n < 2000);
      check($sformatf("period%0d", f), n, 812);
      check($sformatf("busy%0d", f), bz, 312);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ws2812_driver.md
WS2812_DRIVER -- requirements
Module: ws2812_driver

Interface
REQ-001 Parameter T0H_CYC, default 4: high time of a 0 bit, in clk cycles.
REQ-002 Parameter T1H_CYC, default 8: high time of a 1 bit, in clk cycles.
REQ-003 Parameter BIT_CYC, default 13: total bit period, in clk cycles.
REQ-004 Parameter LATCH_CYC, default 500: low latch interval between frames, in clk cycles.
REQ-005 clk  input  1  single block clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 level0  input  8  red level.
REQ-008 level1  input  8  green level.
REQ-009 level2  input  8  blue level.
REQ-010 enable  input  1  high permits a new frame to start at the end of a latch interval.
REQ-011 led_dout  output  1  WS2812 serial data line; flop output.
REQ-012 busy  output  1  high while a frame's 24 bits are being sent.
REQ-013 frame_done  output  1  one-cycle pulse after the last bit of a frame.

Function
REQ-014 The block SHALL have exactly two states: LATCH and SEND.
REQ-015 In LATCH, led_dout SHALL be 0; the state SHALL last LATCH_CYC cycles and then extend while enable is low.
REQ-016 On the final LATCH cycle with enable high:
- the block SHALL capture {level1, level0, level2} (GRB) into a 24-bit shift register;
- it SHALL enter SEND on the next cycle with bit index 0 and cycle count 0.
REQ-017 In SEND, bits SHALL go out MSB-first: G[7] first, B[0] last.
REQ-018 In each bit period, led_dout SHALL be high for T1H_CYC (bit=1) or T0H_CYC (bit=0) cycles, then low for the rest of BIT_CYC; bits SHALL be back-to-back with no gap.
REQ-019 led_dout SHALL be registered: it follows the internal state/counter with exactly one cycle of latency.
REQ-020 After the last cycle of bit 23:
- state SHALL return to LATCH with its count cleared;
- frame_done SHALL be high for exactly one cycle, the first LATCH cycle.
REQ-021 Level inputs SHALL be sampled only at frame start; changes during SEND SHALL NOT affect the frame in flight.
REQ-022 enable SHALL be ignored during SEND; deasserting it SHALL NOT truncate a frame.
REQ-023 busy SHALL be high exactly in SEND cycles, aligned with state (not delayed like led_dout).
REQ-024 Counter width SHALL be $clog2 of max(BIT_CYC, LATCH_CYC) + 1.
- Counters SHALL never wrap mid-interval.
- Parameters SHALL be legal only if 0 < T0H_CYC < T1H_CYC < BIT_CYC and LATCH_CYC >= 1; elaboration SHALL fail otherwise.
REQ-025 With enable constantly high, the frame period SHALL be exactly 24*BIT_CYC + LATCH_CYC cycles.

Reset
REQ-026 While reset is high:
- state SHALL be LATCH, all counts 0, shift register 0;
- led_dout, busy and frame_done SHALL all be 0.
REQ-027 Reset asserted mid-frame SHALL force led_dout to 0 on the next edge and abandon the frame.
REQ-028 After reset deasserts, a full LATCH_CYC interval SHALL precede the first frame. With enable high, the first led_dout rise SHALL come LATCH_CYC+1 cycles after the first edge with reset low.

Structure
REQ-029 Package ws2812_pkg SHALL hold:
- the state enumeration (LATCH, SEND);
- default timing constants for a 10 MHz clk (T0H 4, T1H 8, BIT 13, LATCH 500).
REQ-030 The design SHALL be a single module with no sub-module; the bit timer and frame sequencer share one cycle counter.

Verification
REQ-031 Reset held 20 cycles with all levels 0xFF -> led_dout, busy and frame_done stay 0 throughout.
REQ-032 G=0xFF, R=0x00, B=0xAA, enable=1 ->
- 8 high pulses of 8 cycles, then 8 of 4 cycles;
- then alternating 8/4/8/4...;
- every rising edge exactly 13 cycles apart;
- frame_done fires 1 cycle after the bit-23 period ends.
REQ-033 Change levels to 0x00 at bit 5 of a frame -> current frame still matches the old value; the next frame is all 4-cycle pulses.
REQ-034 enable=0 before LATCH ends -> led_dout stays low beyond 500 cycles; raise enable -> capture that cycle, first rise 2 cycles later.
REQ-035 Assert reset during bit 10 high phase -> led_dout 0 next cycle; after release, the first rise comes LATCH_CYC+1 cycles later.
REQ-036 Free-run 3 frames -> frame_done pulses are exactly 812 cycles apart, and busy is high for exactly 312 cycles per frame.
